timed_serial_adder: RTL and testbench

Downstream consumer of the 8-phase timing generator (ring/Johnson counter decoded to one-hot T0..T7). On a start request it loads two operands, waits for the next T0, then adds them bit-serially LSB-first, one bit per timing phase, finishing on T7. The block is the first datapath stage driven by the timing generator's phase outputs.

---
 rtl/timing_pkg.sv | 19 +
 rtl/serial_add_cell.sv | 28 ++
 rtl/timed_serial_adder.sv | 127 ++++++++++++
 tb/tb_timed_serial_adder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/timing_pkg.sv
// Shared timing-generator constants: phase count, phase indices, FSM state encoding.
package timing_pkg;

    localparam int unsigned NUM_PHASES = 8;
    localparam int unsigned T0_IDX     = 0;
    localparam int unsigned T7_IDX     = 7;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ARMED = 2'd1;
    localparam state_t SHIFT = 2'd2;
    localparam state_t DONE  = 2'd3;

    function automatic logic is_one_hot(input logic [NUM_PHASES-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/serial_add_cell.sv
// One-bit full adder with registered carry; clear forces carry to 0, en advances it.
module serial_add_cell (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic s,
    output logic c_next
);

    logic c_q;

    assign s      = a ^ b ^ c_q;
    assign c_next = (a & b) | (a & c_q) | (b & c_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            c_q <= 1'b0;
        end else if (clear) begin
            c_q <= 1'b0;
        end else if (en) begin
            c_q <= c_next;
        end
    end

endmodule

// File: rtl/timed_serial_adder.sv
// Bit-serial adder paced by the one-hot T0..T7 phase vector of the timing generator.
// Define PHASE_CHECK_EN to enable the sticky one-hot check on t (phase_err).
module timed_serial_adder
    import timing_pkg::*;
#(
    parameter int unsigned WIDTH = 8  // must equal NUM_PHASES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PHASES-1:0] t,
    input  logic                  start,
    input  logic [WIDTH-1:0]      a_in,
    input  logic [WIDTH-1:0]      b_in,
    output logic [WIDTH-1:0]      sum,
    output logic                  cout,
    output logic                  busy,
    output logic                  done,
    output logic                  phase_err
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             cout_q;
    logic             load, step, final_step;
    logic             s_bit, c_next;
    logic             viol, start_ok;

`ifdef PHASE_CHECK_EN
    logic phase_err_q;

    assign viol      = ~is_one_hot(t);
    assign phase_err = phase_err_q;
    assign start_ok  = start & ~phase_err_q & ~viol;

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_err_q <= 1'b0;
        end else if (viol) begin
            phase_err_q <= 1'b1;
        end
    end
`else
    // Only T0 and T7 are decoded when the check is compiled out.
    logic unused_t;
    assign unused_t  = ^t[NUM_PHASES-2:1];
    assign viol      = 1'b0;
    assign phase_err = 1'b0;
    assign start_ok  = start;
`endif

    serial_add_cell u_cell (
        .clk    (clk),
        .reset  (reset),
        .clear  (load),
        .en     (step),
        .a      (a_q[0]),
        .b      (b_q[0]),
        .s      (s_bit),
        .c_next (c_next)
    );

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        step       = 1'b0;
        final_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    load    = 1'b1;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (viol) begin
                    state_d = IDLE;
                end else if (t[T0_IDX]) begin
                    step    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (viol) begin
                    state_d = IDLE;
                end else begin
                    step = 1'b1;
                    if (t[T7_IDX]) begin
                        final_step = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                a_q <= a_in;
                b_q <= b_in;
            end else if (step) begin
                // Sum bits enter at the MSB so A holds the result after the last step.
                a_q <= {s_bit, a_q[WIDTH-1:1]};
                b_q <= b_q >> 1;
            end
            if (final_step) begin
                sum_q  <= {s_bit, a_q[WIDTH-1:1]};
                cout_q <= c_next;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = (state_q == ARMED) || (state_q == SHIFT);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_timed_serial_adder.sv
// Directed self-checking bench for timed_serial_adder with a free-running one-hot phase ring.
module tb_timed_serial_adder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] t;
    logic       start;
    logic [7:0] a_in, b_in;
    logic [7:0] sum;
    logic       cout, busy, done, phase_err;

    logic [2:0] ph = 3'd0;
    logic       ovr_en = 1'b0;
    logic [7:0] t_ovr = 8'h00;
    int         n_checks = 0;
    int         n_errors = 0;
    int         done_cnt = 0;
    int         lat;
    int         d0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ph <= ph + 3'd1;
        if (done) done_cnt <= done_cnt + 1;
    end

    assign t = ovr_en ? t_ovr : (8'b1 << ph);

    timed_serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .t         (t),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy),
        .done      (done),
        .phase_err (phase_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive start for the cycle whose phase is p; returns at the negedge after that edge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [2:0] p);
        @(negedge clk);
        for (int i = 0; i < 16 && ph != p; i++) @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
    endtask

    task automatic finish(input string tag, input logic [7:0] es, input logic ec, input int el);
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, lat, el);
        check_eq({tag, "_sum"}, sum, es);
        check_eq({tag, "_cout"}, cout, ec);
        check_eq({tag, "_busy_in_done"}, busy, 1'b0);
        @(negedge clk);
        check_eq({tag, "_done_width"}, done, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_sum", sum, 8'h00);
        check_eq("rst_cout", cout, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_phase_err", phase_err, 1'b0);
        reset = 1'b1;

        // Start in T7: one ARMED cycle, latency 9.
        launch(8'h5A, 8'h3C, 3'd7);
        check_eq("t1_busy", busy, 1'b1);
        finish("t1", 8'h96, 1'b0, 9);

        // Start in T1: seven ARMED cycles, latency 15.
        launch(8'hFF, 8'h01, 3'd1);
        finish("t2", 8'h00, 1'b1, 15);

        // Second start during SHIFT must be ignored.
        d0 = done_cnt;
        launch(8'h12, 8'h34, 3'd7);
        repeat (2) begin
            @(negedge clk);
            lat++;
        end
        check_eq("t3_busy_shift", busy, 1'b1);
        a_in  = 8'hAA;
        b_in  = 8'hBB;
        start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        finish("t3", 8'h46, 1'b0, 9);
        repeat (20) @(negedge clk);
        check_eq("t3_one_done", done_cnt - d0, 1);
        check_eq("t3_still_idle", busy, 1'b0);

        // Reset in the 4th SHIFT cycle abandons the add and clears the result.
        d0 = done_cnt;
        launch(8'h0F, 8'h0F, 3'd7);
        repeat (4) begin
            @(negedge clk);
            lat++;
        end
        check_eq("t4_busy_pre", busy, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_eq("t4_busy", busy, 1'b0);
        check_eq("t4_sum", sum, 8'h00);
        check_eq("t4_cout", cout, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("t4_no_done", done_cnt - d0, 0);

`ifdef PHASE_CHECK_EN
        d0 = done_cnt;
        launch(8'h21, 8'h43, 3'd7);
        repeat (3) @(negedge clk);
        ovr_en = 1'b1;
        t_ovr  = 8'b0000_0101;
        @(negedge clk);
        ovr_en = 1'b0;
        check_eq("t5_phase_err", phase_err, 1'b1);
        check_eq("t5_busy", busy, 1'b0);
        launch(8'h01, 8'h02, 3'd3);
        check_eq("t5_start_ignored", busy, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("t5_no_done", done_cnt - d0, 0);
        check_eq("t5_sum_kept", sum, 8'h00);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_eq("t5_err_cleared", phase_err, 1'b0);
`endif

        // Two consecutive adds, each with one done pulse.
        d0 = done_cnt;
        launch(8'h01, 8'h01, 3'd3);
        finish("t6a", 8'h02, 1'b0, 13);
        launch(8'h80, 8'h80, 3'd0);
        finish("t6b", 8'h00, 1'b1, 16);
        check_eq("t6_done_cnt", done_cnt - d0, 2);
        check_eq("t6_phase_err", phase_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
